// File: rtl/io_port_unit.sv
`timescale 1ns/1ps
// Retire-time privileged I/O unit: per-channel TX FIFOs, blocking RX reads and
// status queries, with a supervisor-mask check on every accepted op.
module io_port_unit #(
    parameter int                DATA_WIDTH = 64,
    parameter int                NUM_CH     = 4,
    parameter int                TX_DEPTH   = 8,
    parameter logic [NUM_CH-1:0] SUP_MASK   = NUM_CH'(4'b0001)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  retire_i,
    input  logic [1:0]            op_kind_i,
    input  logic [3:0]            chan_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  cpl_i,
    input  logic                  cpl_recompute_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_valid_o,
    output logic                  fault_o,
    output logic [1:0]            fault_code_o,
    output logic [NUM_CH-1:0]     tx_valid_o,
    output logic [8*NUM_CH-1:0]   tx_data_o,
    input  logic [NUM_CH-1:0]     tx_ready_i,
    input  logic [NUM_CH-1:0]     rx_valid_i,
    input  logic [8*NUM_CH-1:0]   rx_data_i,
    output logic [NUM_CH-1:0]     rx_ready_o
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

    localparam logic [1:0] OP_OUT   = 2'd0;
    localparam logic [1:0] OP_IN    = 2'd1;
    localparam logic [1:0] OP_STAT  = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;
    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_PERM  = 2'd1;
    localparam logic [1:0] FC_BADCH = 2'd2;
    localparam logic [1:0] FC_BADOP = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_TX = 2'd1,
        WAIT_RX = 2'd2
    } state_t;

    state_t                  state_r;
    logic [7:0]              mem_r    [NUM_CH][TX_DEPTH];
    logic [PW-1:0]           wr_ptr_r [NUM_CH];
    logic [PW-1:0]           rd_ptr_r [NUM_CH];
    logic [CW-1:0]           count_r  [NUM_CH];
    logic [NUM_CH-1:0]       pend_sel_r;
    logic [7:0]              pend_byte_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    rdata_valid_r;
    logic                    fault_r;
    logic [1:0]              fault_code_r;

    logic                    accept_s;
    logic [NUM_CH-1:0]       chan_sel_s;
    logic [NUM_CH-1:0]       full_s;
    logic [NUM_CH-1:0]       push_s;
    logic [NUM_CH-1:0]       pop_s;
    logic [CW-1:0]           sel_count_s;
    logic                    sel_full_s;
    logic                    sel_rx_valid_s;
    logic                    sup_hit_s;
    logic                    pend_full_s;
    logic                    pend_rx_valid_s;
    logic [7:0]              pend_rx_byte_s;
    logic [7:0]              push_byte_s;
    logic [1:0]              fault_kind_s;
    logic                    fault_s;

    // Status word: count in [4:0], sampled rx_valid in bit 8, full flag in bit 9.
    function automatic logic [DATA_WIDTH-1:0] stat_word(input logic [CW-1:0] cnt,
                                                        input logic rxv,
                                                        input logic full);
        logic [31:0]           cnt_ext;
        logic [DATA_WIDTH-1:0] w;
        cnt_ext = 32'(cnt);
        w       = {DATA_WIDTH{1'b0}};
        w[4:0]  = cnt_ext[4:0];
        w[8]    = rxv;
        w[9]    = full;
        return w;
    endfunction

    assign done_o   = !cpl_recompute_i && (state_r == IDLE);
    assign accept_s = retire_i && done_o;

    // Channel decode and per-channel status muxing for the requested and pending channel.
    always_comb begin
        chan_sel_s      = {NUM_CH{1'b0}};
        full_s          = {NUM_CH{1'b0}};
        sel_count_s     = {CW{1'b0}};
        sel_rx_valid_s  = 1'b0;
        pend_rx_byte_s  = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            full_s[c]      = (count_r[c] == FULL_CNT);
            chan_sel_s[c]  = ({1'b0, chan_i} == 5'(c));
            sel_count_s    = sel_count_s | (count_r[c] & {CW{chan_sel_s[c]}});
            sel_rx_valid_s = sel_rx_valid_s | (rx_valid_i[c] & chan_sel_s[c]);
            pend_rx_byte_s = pend_rx_byte_s | (rx_data_i[8*c +: 8] & {8{pend_sel_r[c]}});
        end
        sel_full_s      = |(chan_sel_s & full_s);
        sup_hit_s       = |(chan_sel_s & SUP_MASK);
        pend_full_s     = |(pend_sel_r & full_s);
        pend_rx_valid_s = |(pend_sel_r & rx_valid_i);
    end

    // Fault classification in priority order: reserved op, bad channel, privilege.
    always_comb begin
        fault_kind_s = FC_NONE;
        if (op_kind_i == OP_RSVD) begin
            fault_kind_s = FC_BADOP;
        end else if ({1'b0, chan_i} >= 5'(NUM_CH)) begin
            fault_kind_s = FC_BADCH;
        end else if (!cpl_i && sup_hit_s) begin
            fault_kind_s = FC_PERM;
        end else begin
            fault_kind_s = FC_NONE;
        end
        fault_s = (fault_kind_s != FC_NONE);
    end

    // Push/pop requests; the full test uses the registered count so a same-cycle pop never frees space.
    always_comb begin
        push_s      = {NUM_CH{1'b0}};
        pop_s       = {NUM_CH{1'b0}};
        push_byte_s = (state_r == WAIT_TX) ? pend_byte_r : wdata_i[7:0];
        for (int c = 0; c < NUM_CH; c++) begin
            pop_s[c] = (count_r[c] != {CW{1'b0}}) && tx_ready_i[c];
            if (state_r == WAIT_TX) begin
                push_s[c] = pend_sel_r[c] && !full_s[c];
            end else begin
                push_s[c] = accept_s && !fault_s && (op_kind_i == OP_OUT)
                            && chan_sel_s[c] && !full_s[c];
            end
        end
    end

    // TX FIFO storage, pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_r[c] <= {PW{1'b0}};
                rd_ptr_r[c] <= {PW{1'b0}};
                count_r[c]  <= {CW{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push_s[c]) begin
                    mem_r[c][wr_ptr_r[c]] <= push_byte_s;
                    wr_ptr_r[c]           <= wr_ptr_r[c] + PW'(1);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PW'(1);
                end
                if (push_s[c] && !pop_s[c]) begin
                    count_r[c] <= count_r[c] + CW'(1);
                end else if (pop_s[c] && !push_s[c]) begin
                    count_r[c] <= count_r[c] - CW'(1);
                end else begin
                    count_r[c] <= count_r[c];
                end
            end
        end
    end

    // Op sequencing FSM with registered result and fault strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            pend_sel_r    <= {NUM_CH{1'b0}};
            pend_byte_r   <= 8'h00;
            rdata_r       <= {DATA_WIDTH{1'b0}};
            rdata_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            fault_code_r  <= 2'd0;
        end else begin
            rdata_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (fault_s) begin
                            fault_r      <= 1'b1;
                            fault_code_r <= fault_kind_s;
                        end else begin
                            case (op_kind_i)
                                OP_OUT: begin
                                    if (sel_full_s) begin
                                        state_r     <= WAIT_TX;
                                        pend_sel_r  <= chan_sel_s;
                                        pend_byte_r <= wdata_i[7:0];
                                    end
                                end
                                OP_IN: begin
                                    state_r    <= WAIT_RX;
                                    pend_sel_r <= chan_sel_s;
                                end
                                OP_STAT: begin
                                    rdata_valid_r <= 1'b1;
                                    rdata_r       <= stat_word(sel_count_s, sel_rx_valid_s, sel_full_s);
                                end
                                default: state_r <= IDLE;
                            endcase
                        end
                    end
                end
                WAIT_TX: begin
                    if (!pend_full_s) begin
                        state_r <= IDLE;
                    end
                end
                WAIT_RX: begin
                    if (pend_rx_valid_s) begin
                        rdata_r       <= DATA_WIDTH'(pend_rx_byte_s);
                        rdata_valid_r <= 1'b1;
                        state_r       <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign rdata_o       = rdata_r;
    assign rdata_valid_o = rdata_valid_r;
    assign fault_o       = fault_r;
    assign fault_code_o  = fault_code_r;
    assign rx_ready_o    = (state_r == WAIT_RX) ? pend_sel_r : {NUM_CH{1'b0}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_tx
        assign tx_valid_o[g]         = (count_r[g] != {CW{1'b0}});
        assign tx_data_o[8*g +: 8]   = mem_r[g][rd_ptr_r[g]];
    end

endmodule

// File: tb/tb_io_port_unit.sv
`timescale 1ns/1ps
// Directed plus randomized bench for io_port_unit against a queue-based reference model.
module tb_io_port_unit;
    localparam int NC = 4;
    localparam int TD = 8;
    localparam logic [3:0] SM = 4'b0001;
    localparam int M_IDLE = 0;
    localparam int M_WTX  = 1;
    localparam int M_WRX  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire = 1'b0;
    logic [1:0]  op_kind = 2'd0;
    logic [3:0]  chan = 4'd0;
    logic [63:0] wdata = 64'd0;
    logic        cpl = 1'b0;
    logic        recompute = 1'b0;
    logic [3:0]  tx_ready = 4'd0;
    logic [3:0]  rx_valid = 4'd0;
    logic [31:0] rx_data = 32'd0;
    logic        done;
    logic [63:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  tx_valid;
    logic [31:0] tx_data;
    logic [3:0]  rx_ready;

    int compared = 0;
    int mismatched = 0;

    logic [7:0]  q [NC][$];
    int          m_state = M_IDLE;
    int          m_ch = 0;
    logic [7:0]  m_byte = 8'd0;
    logic [63:0] m_rdata = 64'd0;
    logic        m_rvalid = 1'b0;
    logic        m_fault = 1'b0;
    logic [1:0]  m_code = 2'd0;

    io_port_unit dut (
        .clk(clk), .rst(rst), .retire_i(retire), .op_kind_i(op_kind), .chan_i(chan),
        .wdata_i(wdata), .cpl_i(cpl), .cpl_recompute_i(recompute), .done_o(done),
        .rdata_o(rdata), .rdata_valid_o(rdata_valid), .fault_o(fault),
        .fault_code_o(fault_code), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .tx_ready_i(tx_ready), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .rx_ready_o(rx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at one clock edge, using the inputs currently applied.
    task automatic model_edge();
        int         sz [NC];
        bit         do_push;
        int         pch;
        logic [7:0] pbyte;
        int         ch;
        do_push = 1'b0;
        pch = 0;
        pbyte = 8'd0;
        ch = int'(chan);
        if (!rst) begin
            for (int c = 0; c < NC; c++) q[c].delete();
            m_state = M_IDLE;
            m_rdata = 64'd0;
            m_rvalid = 1'b0;
            m_fault = 1'b0;
            m_code = 2'd0;
            return;
        end
        for (int c = 0; c < NC; c++) sz[c] = q[c].size();
        m_rvalid = 1'b0;
        m_fault = 1'b0;
        if (m_state == M_IDLE) begin
            if (retire && !recompute) begin
                if (op_kind == 2'd3) begin
                    m_fault = 1'b1; m_code = 2'd3;
                end else if (ch >= NC) begin
                    m_fault = 1'b1; m_code = 2'd2;
                end else if (!cpl && SM[ch]) begin
                    m_fault = 1'b1; m_code = 2'd1;
                end else if (op_kind == 2'd0) begin
                    if (sz[ch] < TD) begin
                        do_push = 1'b1; pch = ch; pbyte = wdata[7:0];
                    end else begin
                        m_state = M_WTX; m_ch = ch; m_byte = wdata[7:0];
                    end
                end else if (op_kind == 2'd1) begin
                    m_state = M_WRX; m_ch = ch;
                end else begin
                    m_rvalid = 1'b1;
                    m_rdata = 64'(sz[ch]) + (rx_valid[ch] ? 64'h100 : 64'h0)
                              + ((sz[ch] == TD) ? 64'h200 : 64'h0);
                end
            end
        end else if (m_state == M_WTX) begin
            if (sz[m_ch] < TD) begin
                do_push = 1'b1; pch = m_ch; pbyte = m_byte; m_state = M_IDLE;
            end
        end else begin
            if (rx_valid[m_ch]) begin
                m_rvalid = 1'b1;
                m_rdata = 64'(rx_data[8*m_ch +: 8]);
                m_state = M_IDLE;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (sz[c] != 0 && tx_ready[c]) void'(q[c].pop_front());
        end
        if (do_push) q[pch].push_back(pbyte);
    endtask

    task automatic check_all();
        chk("done", 64'(done), 64'(!recompute && m_state == M_IDLE));
        chk("rdata_valid", 64'(rdata_valid), 64'(m_rvalid));
        chk("rdata", rdata, m_rdata);
        chk("fault", 64'(fault), 64'(m_fault));
        chk("fault_code", 64'(fault_code), 64'(m_code));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("tx_valid%0d", c), 64'(tx_valid[c]), 64'(q[c].size() != 0));
            if (q[c].size() != 0) chk($sformatf("tx_data%0d", c), 64'(tx_data[8*c +: 8]), 64'(q[c][0]));
            chk($sformatf("rx_ready%0d", c), 64'(rx_ready[c]), 64'(m_state == M_WRX && m_ch == c));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic issue(input logic [1:0] k, input logic [3:0] ch, input logic [63:0] d, input logic p);
        retire = 1'b1; op_kind = k; chan = ch; wdata = d; cpl = p;
        step();
        retire = 1'b0;
    endtask

    initial begin
        // reset, then a supervisor OUT on channel 0 and its drain
        step(); step();
        rst = 1'b1;
        step();
        chk("reset_done", 64'(done), 64'd1);
        issue(2'd0, 4'd0, 64'h41, 1'b1);
        chk("plan_tx0_valid", 64'(tx_valid[0]), 64'd1);
        chk("plan_tx0_data", 64'(tx_data[7:0]), 64'h41);
        tx_ready[0] = 1'b1; step(); tx_ready[0] = 1'b0;
        chk("plan_tx0_drained", 64'(tx_valid[0]), 64'd0);

        // faults and a permitted user push
        issue(2'd0, 4'd0, 64'h55, 1'b0);
        chk("plan_perm", 64'(fault_code), 64'd1);
        issue(2'd0, 4'd1, 64'h22, 1'b0);
        chk("plan_user_push", 64'(tx_data[15:8]), 64'h22);
        issue(2'd0, 4'd5, 64'h33, 1'b1);
        chk("plan_badch", 64'(fault_code), 64'd2);
        issue(2'd3, 4'd1, 64'h44, 1'b1);
        chk("plan_badop", 64'(fault_code), 64'd3);
        tx_ready[1] = 1'b1; step(); tx_ready[1] = 1'b0;

        // overfill channel 2 into WAIT_TX, then release one slot
        for (int i = 0; i < 9; i++) issue(2'd0, 4'd2, 64'(8'hA0 + i), 1'b0);
        chk("plan_wait_tx_done", 64'(done), 64'd0);
        step();
        tx_ready[2] = 1'b1; step(); tx_ready[2] = 1'b0;
        step();
        chk("plan_wait_tx_release", 64'(done), 64'd1);

        // blocking IN on channel 1
        issue(2'd1, 4'd1, 64'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("plan_in_ready", 64'(rx_ready[1]), 64'd1);
        end
        rx_valid[1] = 1'b1; rx_data[15:8] = 8'h7F;
        step();
        rx_valid[1] = 1'b0;
        chk("plan_in_data", rdata, 64'h7F);
        chk("plan_in_valid", 64'(rdata_valid), 64'd1);
        step();

        // drain channel 2 to 3 entries, STAT, then recompute gating
        tx_ready[2] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tx_ready[2] = 1'b0;
        rx_valid[2] = 1'b1;
        issue(2'd2, 4'd2, 64'd0, 1'b1);
        rx_valid[2] = 1'b0;
        chk("plan_stat", rdata, 64'h103);
        recompute = 1'b1;
        issue(2'd0, 4'd3, 64'h99, 1'b1);
        chk("plan_recompute_done", 64'(done), 64'd0);
        chk("plan_recompute_ignored", 64'(tx_valid[3]), 64'd0);
        recompute = 1'b0;

        // reset in the middle of WAIT_RX with a non-empty FIFO
        issue(2'd1, 4'd0, 64'd0, 1'b1);
        step();
        rst = 1'b0; step(); step(); rst = 1'b1;
        step();
        chk("plan_rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("plan_rst_rx_ready", 64'(rx_ready), 64'd0);
        chk("plan_rst_done", 64'(done), 64'd1);
        chk("plan_rst_rvalid", 64'(rdata_valid), 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            retire    = 1'($urandom_range(0, 1));
            op_kind   = 2'($urandom_range(0, 3));
            chan      = 4'($urandom_range(0, 5));
            wdata     = {$urandom, $urandom};
            cpl       = 1'($urandom_range(0, 1));
            recompute = ($urandom_range(0, 7) == 0);
            tx_ready  = 4'($urandom & ($urandom | 32'h5));
            rx_valid  = 4'($urandom & $urandom);
            rx_data   = $urandom;
            rst       = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Privileged retire-time I/O execution unit with NUM_CH byte channels. It replaces the single-shot, simulation-only I/O path.
- Each retired I/O op is checked against a per-channel supervisor mask, then executes one of three kinds:
  - OUT: push a byte into the channel's TX FIFO.
  - IN: block until the channel's RX source offers a byte.
  - STAT: read channel status.
- Sits beside the ALU/LSU units on the retire port; the pipeline stalls on done_o.
- Faults are reported on ports; the unit never terminates simulation.

Parameters:
- DATA_WIDTH, 64, width of wdata_i/rdata_o.
- NUM_CH, 4, number of I/O channels (1..16).
- TX_DEPTH, 8, entries per TX FIFO; power of two, >=2.
- SUP_MASK, 4'b0001, bit c=1 makes channel c supervisor-only; width NUM_CH.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- retire_i  in  1  op retiring this cycle
- op_kind_i  in  2  0=OUT, 1=IN, 2=STAT, 3=reserved
- chan_i  in  4  target channel
- wdata_i  in  DATA_WIDTH  OUT payload; bits [7:0] used
- cpl_i  in  1  0=USER, 1=SUPERVISOR
- cpl_recompute_i  in  1  privilege level being recomputed
- done_o  out  1  unit can accept a retire
- rdata_o  out  DATA_WIDTH  IN/STAT result
- rdata_valid_o  out  1  one-cycle result strobe
- fault_o  out  1  one-cycle fault strobe
- fault_code_o  out  2  1=PERM, 2=BADCH, 3=BADOP
- tx_valid_o  out  NUM_CH  per-channel TX FIFO non-empty
- tx_data_o  out  8*NUM_CH  per-channel FIFO head; channel c at [8c+7:8c]
- tx_ready_i  in  NUM_CH  sink accepts head
- rx_valid_i  in  NUM_CH  source offers byte
- rx_data_i  in  8*NUM_CH  source bytes
- rx_ready_o  out  NUM_CH  unit takes rx byte

Behaviour:
- Reset and clocking: reset rst, synchronous, active-low; clock clk. While rst is low:
  - FSM goes to IDLE; all FIFOs are emptied (pointers and counts = 0).
  - rdata_o, rdata_valid_o, fault_o, fault_code_o, tx_valid_o, rx_ready_o are 0.
  - A pending OUT or IN is dropped with no result.
- done_o is combinational: done_o = !cpl_recompute_i && state==IDLE. A retire_i arriving while done_o=0 is ignored, with no side effects.
- FSM states are IDLE, WAIT_TX and WAIT_RX. An accepted retire is checked in this priority order:
  1. op_kind_i==3 gives fault BADOP.
  2. chan_i>=NUM_CH gives fault BADCH.
  3. cpl_i==USER with SUP_MASK[chan_i]=1 gives fault PERM.
- A fault sets fault_o=1 and fault_code_o for exactly one cycle after the accept edge. State stays IDLE and no FIFO or RX side effect occurs. fault_code_o holds its value until the next fault.
- OUT:
  - If count[chan]<TX_DEPTH, wdata_i[7:0] is written at the accept edge and the FSM stays IDLE.
  - Otherwise chan and byte are latched and the FSM enters WAIT_TX. The write happens on the first edge where count<TX_DEPTH, then the FSM returns to IDLE.
  - The full test uses the registered count: a pop in the same cycle does not free space for that cycle's push.
- TX FIFO:
  - tx_valid_o[c] = count[c]!=0; tx_data_o shows the head entry.
  - A pop occurs on an edge where tx_valid_o[c] && tx_ready_i[c].
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo TX_DEPTH.
  - A pushed byte is visible on tx_valid_o the cycle after the push edge.
- IN:
  - FSM enters WAIT_RX; rx_ready_o[chan]=1 while in WAIT_RX, and all other bits are 0.
  - On an edge with rx_valid_i[chan]=1, the byte is captured and zero-extended into rdata_o. rdata_valid_o=1 for one cycle and the FSM returns to IDLE.
  - Minimum latency is 2 cycles from the accept.
- STAT: one cycle after the accept, rdata_valid_o=1 and rdata_o is:
  - bits [4:0] = count[chan]
  - bit 8 = rx_valid_i[chan], sampled at the accept edge
  - bit 9 = (count==TX_DEPTH)
  - all other bits 0
- rdata_o holds its last value when rdata_valid_o=0.
- cpl_recompute_i only gates done_o; it does not abort WAIT states.

Test Plan:
- Reset low for 2 cycles then high; SUPERVISOR OUT ch0 wdata=0x41 -> tx_valid_o[0]=1 next cycle with tx_data_o[7:0]=0x41; ready pulse -> tx_valid_o[0]=0.
- USER OUT ch0 (SUP_MASK=0001) -> fault_o pulse with code 1, no push; USER OUT ch1 -> push succeeds; chan_i=5 -> code 2; op_kind_i=3 -> code 3.
- tx_ready_i[2]=0; nine OUTs to ch2 -> 8 entries stored, 9th enters WAIT_TX with done_o=0; one pop -> push on next edge, done_o=1, count stays 8.
- IN ch1 with rx_valid_i low for 5 cycles -> rx_ready_o[1]=1 and done_o=0 throughout; rx byte 0x7F -> rdata_o=0x7F, rdata_valid_o pulse, back to IDLE.
- STAT ch2 with 3 entries and rx_valid_i[2]=1 -> rdata_o=0x103; cpl_recompute_i=1 -> done_o=0 and retire ignored.
- rst low asserted during WAIT_RX and with a non-empty FIFO -> after release, tx_valid_o=0, rx_ready_o=0, done_o=1, no rdata_valid_o.
